// File: rtl/turf_pkg.sv
// Shared types and sizing helpers for the turf ownership-RAM controller.
package turf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCAN,
    ST_DRAIN,
    ST_RESULT,
    ST_CLEAR,
    ST_DONE
  } state_t;

  // Owner code 0 marks an unclaimed cell; player i owns code i+1.
  localparam int CODE_NONE = 0;

  // Default board: 256 x 128 cells, 4 players, 3-bit owner codes.
  localparam int DEF_PLAYERS = 4;
  localparam int DEF_X_BITS  = 8;
  localparam int DEF_Y_BITS  = 7;
  localparam int DEF_CODE_W  = 3;

  // One spare bit so a board fully owned by one player still fits.
  function automatic int cnt_w(input int xb, input int yb);
    return xb + yb + 1;
  endfunction

  // Width of a player index; kept at least 1 so single-player builds elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turf_argmax.sv
// Registered max/tie reduction over the per-player tallies.
// Lowest index wins among equal maxima; tie flags any other index at the max.
module turf_argmax
  import turf_pkg::*;
#(
  parameter int N     = DEF_PLAYERS,
  parameter int CNT_W = 16,
  parameter int WIN_W = 2
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic [N-1:0][CNT_W-1:0]   i_counts,
  output logic [WIN_W-1:0]          o_winner,
  output logic                      o_tie
);

  logic [WIN_W-1:0] w_best;
  logic [CNT_W-1:0] w_max;
  logic             w_tie;

  // Strict greater-than keeps the earliest index on equal counts.
  always_comb begin
    w_best = '0;
    w_max  = i_counts[0];
    for (int i = 1; i < N; i++) begin
      if (i_counts[i] > w_max) begin
        w_max  = i_counts[i];
        w_best = WIN_W'(i);
      end
    end
    w_tie = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((i_counts[i] == w_max) && (WIN_W'(i) != w_best)) w_tie = 1'b1;
    end
  end

  // Capture the reduction for the single result cycle; clear on restart.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      o_winner <= '0;
      o_tie    <= 1'b0;
    end else if (i_clr) begin
      o_winner <= '0;
      o_tie    <= 1'b0;
    end else if (i_en) begin
      o_winner <= w_best;
      o_tie    <= w_tie;
    end
  end

endmodule

// File: rtl/turf_tally.sv
// Ownership-RAM controller for the turf game.
// Writes each player's cell once per movement tick while running; once the
// game stops, scans the whole RAM, tallies cells per owner and reports the
// winner. Define TURF_CLEAR_EN to wipe the board after the result is latched.
module turf_tally
  import turf_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_PLAYERS,
  parameter int X_BITS      = DEF_X_BITS,
  parameter int Y_BITS      = DEF_Y_BITS,
  parameter int CODE_W      = DEF_CODE_W,
  localparam int A_W        = X_BITS + Y_BITS,
  localparam int CNT_W      = cnt_w(X_BITS, Y_BITS),
  localparam int WIN_W      = idx_w(NUM_PLAYERS)
) (
  input  logic                           CLOCK_50,
  input  logic                           resetn,
  input  logic                           running,
  input  logic                           pos_valid,
  input  logic [NUM_PLAYERS*X_BITS-1:0]  pos_x,
  input  logic [NUM_PLAYERS*Y_BITS-1:0]  pos_y,
  output logic [A_W-1:0]                 address,
  output logic                           wren,
  output logic [CODE_W-1:0]              data_to_ram,
  input  logic [CODE_W-1:0]              ram_output,
  output logic [NUM_PLAYERS*CNT_W-1:0]   counts,
  output logic [WIN_W-1:0]               winner,
  output logic                           tie,
  output logic                           done
);

  state_t r_state, w_state_nxt;

  logic [NUM_PLAYERS-1:0][X_BITS-1:0] r_px;
  logic [NUM_PLAYERS-1:0][Y_BITS-1:0] r_py;
  logic [WIN_W-1:0]                   r_k;
  logic [A_W-1:0]                     r_ptr;
  logic                               r_seen;
  logic                               r_rd_vld;
  logic [NUM_PLAYERS-1:0][CNT_W-1:0]  w_cnt;

  logic [A_W-1:0]    w_addr;
  logic              w_wren;
  logic [CODE_W-1:0] w_data;
  logic              w_done;
  logic              w_last_k;
  logic              w_ptr_last;
  logic              w_scan_start;
  logic              w_restart;

  assign w_last_k     = (r_k == WIN_W'(NUM_PLAYERS - 1));
  assign w_ptr_last   = &r_ptr;
  assign w_scan_start = (w_state_nxt == ST_SCAN) && (r_state != ST_SCAN);
  assign w_restart    = (r_state == ST_DONE) && running;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and RAM-port outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_addr      = '0;
    w_wren      = 1'b0;
    w_data      = '0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pos_valid && running)   w_state_nxt = ST_WRITE;
        else if (!running && r_seen) w_state_nxt = ST_SCAN;
      end
      ST_WRITE: begin
        // Players go out in index order, so the higher index lands last on a shared cell.
        w_addr = {r_px[r_k], r_py[r_k]};
        w_wren = 1'b1;
        w_data = CODE_W'(r_k) + CODE_W'(1);
        if (w_last_k) w_state_nxt = running ? ST_IDLE : ST_SCAN;
      end
      ST_SCAN: begin
        w_addr = r_ptr;
        if (w_ptr_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN:  w_state_nxt = ST_RESULT;
      ST_RESULT: begin
`ifdef TURF_CLEAR_EN
        w_state_nxt = ST_CLEAR;
`else
        w_state_nxt = ST_DONE;
`endif
      end
      ST_CLEAR: begin
        w_addr = r_ptr;
        w_wren = 1'b1;
        w_data = CODE_W'(CODE_NONE);
        if (w_ptr_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        // Level test: running may already have come back during the scan.
        if (running) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign address     = w_addr;
  assign wren        = w_wren;
  assign data_to_ram = w_data;
  assign done        = w_done;

  // Burst index, sweep pointer, position latch, run tracking and read-valid tag.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_k      <= '0;
      r_ptr    <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_seen   <= 1'b0;
      r_rd_vld <= 1'b0;
    end else begin
      r_k      <= (r_state == ST_WRITE && !w_last_k) ? r_k + WIN_W'(1) : '0;
      r_ptr    <= (r_state == ST_SCAN || r_state == ST_CLEAR) ? r_ptr + A_W'(1) : '0;
      if (r_state == ST_IDLE && w_state_nxt == ST_WRITE) begin
        r_px <= pos_x;
        r_py <= pos_y;
      end
      if (running)           r_seen <= 1'b1;
      else if (w_scan_start) r_seen <= 1'b0;
      // Read data for a scan address arrives one cycle later.
      r_rd_vld <= (r_state == ST_SCAN);
    end
  end

  // Per-player tally: bump when the returning code matches this player.
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_cnt
    logic [CNT_W-1:0] r_c;
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)                        r_c <= '0;
      else if (w_scan_start || w_restart) r_c <= '0;
      else if (r_rd_vld && ram_output == CODE_W'(g + 1)) r_c <= r_c + CNT_W'(1);
    end
    assign w_cnt[g] = r_c;
  end

  assign counts = w_cnt;

  turf_argmax #(
    .N     (NUM_PLAYERS),
    .CNT_W (CNT_W),
    .WIN_W (WIN_W)
  ) u_argmax (
    .gclk     (CLOCK_50),
    .grst_n   (resetn),
    .i_en     (r_state == ST_RESULT),
    .i_clr    (w_restart),
    .i_counts (w_cnt),
    .o_winner (winner),
    .o_tie    (tie)
  );

endmodule

// File: tb/tb_turf_tally.sv
// Scoreboard bench for turf_tally on a 8x4 board with a 1-cycle-read RAM model.
module tb_turf_tally;

  localparam int NP = 4, XB = 3, YB = 2, CW = 3, AW = 5, CNTW = 6, DEPTH = 32;
`ifdef TURF_CLEAR_EN
  localparam int SCAN_LAT = 66;
`else
  localparam int SCAN_LAT = 34;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              running = 1'b0;
  logic              pos_valid = 1'b0;
  logic [NP*XB-1:0]  pos_x = '0;
  logic [NP*YB-1:0]  pos_y = '0;
  logic [AW-1:0]     address;
  logic              wren;
  logic [CW-1:0]     data_to_ram;
  logic [CW-1:0]     ram_output;
  logic [NP*CNTW-1:0] counts;
  logic [1:0]        winner;
  logic              tie;
  logic              done;

  always #5 clk = ~clk;

  turf_tally #(.NUM_PLAYERS(NP), .X_BITS(XB), .Y_BITS(YB), .CODE_W(CW)) dut (
    .CLOCK_50    (clk),
    .resetn      (rstn),
    .running     (running),
    .pos_valid   (pos_valid),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .address     (address),
    .wren        (wren),
    .data_to_ram (data_to_ram),
    .ram_output  (ram_output),
    .counts      (counts),
    .winner      (winner),
    .tie         (tie),
    .done        (done)
  );

  // RAM model with a backdoor image load for seeding boards.
  logic [CW-1:0] mem    [DEPTH];
  logic [CW-1:0] bd_img [DEPTH];
  logic          bd_load = 1'b0;
  always @(posedge clk) begin
    if (bd_load)   mem <= bd_img;
    else if (wren) mem[address] <= data_to_ram;
    ram_output <= mem[address];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct packed { logic [AW-1:0] a; logic [CW-1:0] d; } wr_t;
  typedef struct packed { logic [NP*CNTW-1:0] c; logic [1:0] w; logic t; } res_t;
  wr_t  wr_q [$];
  res_t res_q [$];
  wr_t  mon_w;
  res_t mon_r;
  logic done_q = 1'b0;

  // Monitor: owner writes (nonzero data) and done rising edges pop the scoreboard.
  always @(negedge clk) begin
    if (wren && data_to_ram != '0) begin
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected addr=%0d data=%0d expected=no write", address, data_to_ram);
      end else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", longint'(address), longint'(mon_w.a));
        chk("wr_data", longint'(data_to_ram), longint'(mon_w.d));
      end
    end
    if (done && !done_q) begin
      if (res_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected actual=1 expected=0");
      end else begin
        mon_r = res_q.pop_front();
        chk("res_counts", longint'(counts), longint'(mon_r.c));
        chk("res_winner", longint'(winner), longint'(mon_r.w));
        chk("res_tie",    longint'(tie),    longint'(mon_r.t));
      end
    end
    done_q <= done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_img();
    bd_load = 1'b1;
    tick(1);
    bd_load = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < DEPTH; i++) bd_img[i] = '0;
  endtask

  task automatic burst(input logic [NP*XB-1:0] x, input logic [NP*YB-1:0] y,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] a3, input bit poke);
    wr_q.push_back({a0, 3'd1});
    wr_q.push_back({a1, 3'd2});
    wr_q.push_back({a2, 3'd3});
    wr_q.push_back({a3, 3'd4});
    pos_x = x; pos_y = y; pos_valid = 1'b1;
    tick(1);
    // Scramble positions after the latch edge; a second pulse must be ignored.
    pos_x = '1; pos_y = '1; pos_valid = poke;
    tick(1);
    pos_valid = 1'b0;
    tick(6);
  endtask

  task automatic scan(input res_t exp_r);
    int cyc;
`ifdef TURF_CLEAR_EN
    int nz;
`endif
    res_q.push_back(exp_r);
    running = 1'b0;
    @(posedge clk);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
    end
    chk("scan_latency", longint'(cyc), longint'(SCAN_LAT));
`ifdef TURF_CLEAR_EN
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nz++;
    chk("clear_board", longint'(nz), 0);
`endif
    running = 1'b1;
    tick(1);
    chk("restart_counts", longint'(counts), 0);
    chk("restart_done",   longint'(done), 0);
    chk("restart_winner", longint'(winner), 0);
    chk("restart_tie",    longint'(tie), 0);
  endtask

  initial begin
    clear_img();
    load_img();
    tick(1);
    chk("rst_address", longint'(address), 0);
    chk("rst_wren",    longint'(wren), 0);
    chk("rst_data",    longint'(data_to_ram), 0);
    chk("rst_counts",  longint'(counts), 0);
    chk("rst_winner",  longint'(winner), 0);
    chk("rst_tie",     longint'(tie), 0);
    chk("rst_done",    longint'(done), 0);
    rstn = 1'b1;
    tick(2);
    running = 1'b1;
    tick(2);

    // p0..p3 at (1,1),(2,0),(7,3),(0,2); extra pulse mid-burst.
    burst({3'd0, 3'd7, 3'd2, 3'd1}, {2'd2, 2'd3, 2'd0, 2'd1}, 5'd5, 5'd8, 5'd31, 5'd2, 1'b1);
    // p1 and p3 collide at (3,3); p0 (0,0), p2 (4,1).
    burst({3'd3, 3'd4, 3'd3, 3'd0}, {2'd3, 2'd1, 2'd3, 2'd0}, 5'd0, 5'd15, 5'd17, 5'd15, 1'b0);
    chk("ram15_owner", longint'(mem[15]), 4);

    // Board: code1 @5,0; code2 @8; code3 @31,17; code4 @2,15.
    scan('{c: {6'd2, 6'd2, 6'd1, 6'd2}, w: 2'd0, t: 1'b1});

    // 6x code1, 6x code2, 2x code4, stray codes 5..7.
    clear_img();
    for (int i = 0; i < 6; i++) bd_img[i] = 3'd1;
    for (int i = 10; i < 16; i++) bd_img[i] = 3'd2;
    bd_img[20] = 3'd4; bd_img[21] = 3'd4;
    bd_img[25] = 3'd5; bd_img[26] = 3'd6; bd_img[27] = 3'd7;
    load_img();
    scan('{c: {6'd2, 6'd0, 6'd6, 6'd6}, w: 2'd0, t: 1'b0 | 1'b1});

    // Unique winner: player 2 holds 3 cells.
    clear_img();
    bd_img[3] = 3'd3; bd_img[9] = 3'd3; bd_img[30] = 3'd3;
    bd_img[12] = 3'd2; bd_img[28] = 3'd7;
    load_img();
    scan('{c: {6'd0, 6'd3, 6'd1, 6'd0}, w: 2'd2, t: 1'b0});

    // Empty board (already wiped by the clear pass when that is built in).
`ifndef TURF_CLEAR_EN
    clear_img();
    load_img();
`endif
    scan('{c: {6'd0, 6'd0, 6'd0, 6'd0}, w: 2'd0, t: 1'b1});

    // Reset in the middle of a scan.
    clear_img();
    for (int i = 0; i < 6; i++) bd_img[i] = 3'd1;
    load_img();
    running = 1'b0;
    for (int i = 0; i < 100 && address != 5'd9; i++) @(negedge clk);
    chk("scan_reached_9", longint'(address), 9);
    chk("pre_reset_count", longint'(counts), 6);
    rstn = 1'b0;
    #1;
    chk("midrst_counts",  longint'(counts), 0);
    chk("midrst_done",    longint'(done), 0);
    chk("midrst_wren",    longint'(wren), 0);
    chk("midrst_address", longint'(address), 0);
    tick(1);
    rstn = 1'b1;
    tick(40);
    chk("post_rst_idle_done", longint'(done), 0);
    chk("post_rst_idle_addr", longint'(address), 0);

    chk("wr_queue_empty",  longint'(wr_q.size()), 0);
    chk("res_queue_empty", longint'(res_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
